// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - RV32I opcode constants, ALU class encodings and decoded control bundle
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_data_mem_if.sv
// rtl/control_data_mem_if.sv - decode/data-memory bus; illegal_op exists only with CTRL_ILLEGAL_OPCODE_EN
interface control_data_mem_if;
    logic [6:0]  opcode;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        reg_write;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [1:0]  alu_op;
    logic [31:0] read_data;
`ifdef CTRL_ILLEGAL_OPCODE_EN
    logic        illegal_op;
`endif

    modport master (
        output opcode, addr, write_data,
        input  reg_write, alu_src, mem_read, mem_write, mem_to_reg, alu_op, read_data
`ifdef CTRL_ILLEGAL_OPCODE_EN
        , input illegal_op
`endif
    );

    modport slave (
        input  opcode, addr, write_data,
        output reg_write, alu_src, mem_read, mem_write, mem_to_reg, alu_op, read_data
`ifdef CTRL_ILLEGAL_OPCODE_EN
        , output illegal_op
`endif
    );
endinterface

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational RV32I main decoder; illegal_op output under CTRL_ILLEGAL_OPCODE_EN
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl
`ifdef CTRL_ILLEGAL_OPCODE_EN
    , output logic     illegal_op
`endif
);

    always_comb begin
        ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD};
`ifdef CTRL_ILLEGAL_OPCODE_EN
        illegal_op = 1'b0;
`endif
        case (opcode)
            OP_RTYPE:  ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_RTYPE};
            OP_IMM:    ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ITYPE};
            OP_LOAD:   ctrl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ALU_ADD};
            OP_STORE:  ctrl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD};
            OP_BRANCH: ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_BRANCH};
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
                       ctrl = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADD};
            default: begin
                // Unknown opcodes must not touch registers or memory.
`ifdef CTRL_ILLEGAL_OPCODE_EN
                illegal_op = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/control_data_mem.sv
// rtl/control_data_mem.sv - main decoder plus word-addressed data memory; optional CTRL_ILLEGAL_OPCODE_EN
module control_data_mem
    import ctrl_pkg::*;
#(
    parameter int MEM_DEPTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    control_data_mem_if.slave   bus
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    ctrl_t              dec_ctrl;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        mem_q [MEM_DEPTH];
    logic [31:0]        mem_d [MEM_DEPTH];
    logic               unused_addr_bits;

    main_decoder u_main_decoder (
        .opcode     (bus.opcode),
        .ctrl       (dec_ctrl)
`ifdef CTRL_ILLEGAL_OPCODE_EN
        , .illegal_op (bus.illegal_op)
`endif
    );

    assign bus.reg_write  = dec_ctrl.reg_write;
    assign bus.alu_src    = dec_ctrl.alu_src;
    assign bus.mem_read   = dec_ctrl.mem_read;
    assign bus.mem_write  = dec_ctrl.mem_write;
    assign bus.mem_to_reg = dec_ctrl.mem_to_reg;
    assign bus.alu_op     = dec_ctrl.alu_op;

    // Byte offset and bits above the array span are dropped, so addresses wrap.
    assign idx              = bus.addr[IDX_W+1:2];
    assign unused_addr_bits = ^{bus.addr[31:IDX_W+2], bus.addr[1:0]};

    always_comb begin
        mem_d = mem_q;
        if (dec_ctrl.mem_write) begin
            mem_d[idx] = bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.read_data = dec_ctrl.mem_read ? mem_q[idx] : 32'h0;

endmodule

// File: tb/tb_control_data_mem.sv
// tb/tb_control_data_mem.sv - scoreboard bench for control_data_mem (directed + random)
module tb_control_data_mem;
    localparam int DEPTH = 64;

    typedef struct {
        string       name;
        logic [6:0]  ctrl;
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    control_data_mem_if bus ();

    control_data_mem #(.MEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [6:0] ref_ctrl(input logic [6:0] op);
        case (op)
            7'b0110011: return 7'b1000010;
            7'b0010011: return 7'b1100011;
            7'b0000011: return 7'b1110100;
            7'b0100011: return 7'b0101000;
            7'b1100011: return 7'b0000001;
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return 7'b1100000;
            default:    return 7'b0000000;
        endcase
    endfunction

    function automatic logic known_op(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", nm, got, exp);
    endtask

    task automatic step(input string nm, input logic [6:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic r);
        exp_t e;
        bus.opcode     = op;
        bus.addr       = a;
        bus.write_data = wd;
        rst            = r;
        e.name = nm;
        e.ctrl = ref_ctrl(op);
        e.rd   = (op == 7'b0000011) ? ref_mem[word_of(a)] : 32'h0;
        e.ill  = ~known_op(op);
        sb.push_back(e);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        end else if (op == 7'b0100011) begin
            ref_mem[word_of(a)] = wd;
        end
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".ctrl"},
                      {25'h0, bus.reg_write, bus.alu_src, bus.mem_read, bus.mem_write,
                       bus.mem_to_reg, bus.alu_op}, {25'h0, e.ctrl});
                check({e.name, ".read_data"}, bus.read_data, e.rd);
`ifdef CTRL_ILLEGAL_OPCODE_EN
                check({e.name, ".illegal_op"}, {31'h0, bus.illegal_op}, {31'h0, e.ill});
`endif
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  op;
        logic [31:0] a;
        logic [6:0]  ops [9];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        rst = 1'b1;
        bus.opcode = 7'b0110011;
        bus.addr = 32'h0;
        bus.write_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step("reset_load",    7'b0000011, 32'h10,  32'h0,        1'b0);
        step("store_dead",    7'b0100011, 32'h4,   32'hDEADBEEF, 1'b0);
        step("load_dead",     7'b0000011, 32'h4,   32'h0,        1'b0);
        step("rtype",         7'b0110011, 32'h4,   32'h55555555, 1'b0);
        step("load_after_r",  7'b0000011, 32'h4,   32'h0,        1'b0);
        step("store_wrap",    7'b0100011, 32'h104, 32'h12345678, 1'b0);
        step("load_wrap",     7'b0000011, 32'h004, 32'h0,        1'b0);
        step("load_unalign",  7'b0000011, 32'h007, 32'h0,        1'b0);
        step("illegal",       7'b1111111, 32'h8,   32'hFFFFFFFF, 1'b0);
        step("illegal2",      7'b1111111, 32'h8,   32'hFFFFFFFF, 1'b0);
        step("load_after_il", 7'b0000011, 32'h8,   32'h0,        1'b0);
        step("store_in_rst",  7'b0100011, 32'hC,   32'hCAFEF00D, 1'b1);
        step("load_after_rs", 7'b0000011, 32'hC,   32'h0,        1'b0);
        step("load_cleared",  7'b0000011, 32'h4,   32'h0,        1'b0);
        step("decode_in_rst", 7'b1101111, 32'h0,   32'h0,        1'b1);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 11))
                9, 10:   op = ($urandom_range(0, 1) == 1) ? 7'b0100011 : 7'b0000011;
                11:      op = 7'($urandom);
                default: op = ops[$urandom_range(0, 8)];
            endcase
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'h0000_003F;
            step("random", op, a, $urandom, ($urandom_range(0, 59) == 0));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
